argmax_readout_sequencer: RTL and testbench
===========================================

Name: argmax_readout_sequencer

Overview:
Control stage directly upstream of the serial-parallel argmax unit. On `start`, it streams a classifier's output logits from the output SRAM into the argmax unit, N logits per cycle:
- clears the argmax unit first;
- reads groups base..base+G-1 with 1-cycle memory latency;
- pulses the argmax enable once per returned group.
When done, it captures the final class index and max value into a result register and presents them on a valid/ready handshake to the host/readout interface.

Parameters:
- WIDTH, 8, bit width of one signed logit.
- N, 8, logits per SRAM word and per argmax step. Power of 2, ≥2.
- SERIAL_ARGMAX_WIDTH, 4, width of the class index. Max classes = 2**SERIAL_ARGMAX_WIDTH.
- ADDR_WIDTH, 4, SRAM word address width.
- GROUP_WIDTH, SERIAL_ARGMAX_WIDTH-$clog2(N) (localparam), width of the group count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a readout. Sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  SRAM word address of group 0. Sampled with start.
- num_groups_m1  in  GROUP_WIDTH  number of groups minus 1 (G-1). Sampled with start.
- busy  out  1  high whenever state != IDLE.
- mem_ren  out  1  SRAM read enable.
- mem_raddr  out  ADDR_WIDTH  SRAM read address.
- mem_rdata  in  N*WIDTH  SRAM read data, valid the cycle after mem_ren. Logit i is at bits [i*WIDTH +: WIDTH].
- argmax_clear  out  1  drives the argmax unit's rst.
- argmax_enable  out  1  drives the argmax unit's enable.
- argmax_data  out  N*WIDTH  equal to mem_rdata (pure pass-through).
- argmax_in  in  SERIAL_ARGMAX_WIDTH  argmax output of the argmax unit.
- max_in  in  WIDTH  max output of the argmax unit (signed).
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_class  out  SERIAL_ARGMAX_WIDTH  captured class index.
- result_max  out  WIDTH  captured max logit (signed).

Behaviour:
- States: IDLE, CLEAR, READ, DRAIN, CAPTURE, HOLD.
- Reset: state=IDLE; mem_ren=0; argmax_enable=0; result_valid=0; result_class=0; result_max=0; group counter=0.
- argmax_clear = rst | (state==CLEAR). It is combinational, so the argmax unit is also cleared whenever this block is reset.
- IDLE:
  - start=1 → latch base_addr and num_groups_m1, go to CLEAR.
  - start is ignored in every other state. It is not queued.
- CLEAR: one cycle, argmax_clear=1 → READ.
- READ:
  - mem_ren=1; mem_raddr = base + k for k = 0..G-1, one per cycle.
  - Address addition is modulo 2**ADDR_WIDTH (wraps).
  - After the issue with k = G-1 → DRAIN.
- argmax_enable is mem_ren delayed by one register stage. It is high exactly G cycles and aligned with the returned mem_rdata.
- DRAIN: one cycle; the last enable is active. → CAPTURE.
- CAPTURE:
  - argmax_in and max_in are final.
  - At the clock edge: result_class <= argmax_in; result_max <= max_in; result_valid <= 1 → HOLD.
- HOLD:
  - result_valid, result_class and result_max are held stable until result_valid & result_ready.
  - On that handshake: result_valid <= 0 → IDLE. A start in the handshake cycle is ignored.
- Latency:
  - start sampled in cycle 0; CLEAR in cycle 1; READ in cycles 2..G+1.
  - argmax_enable high in cycles 3..G+2; DRAIN in cycle G+2; CAPTURE in cycle G+3.
  - result_valid=1 from cycle G+4.
- result_ready while result_valid=0 has no effect.
- num_groups_m1 = 0: a single read; DRAIN follows after one READ cycle.
- num_groups_m1 all ones: 2**GROUP_WIDTH groups; the class index covers the full range.
- Tie semantics are defined by the argmax unit (strict >): the earliest class wins.
  - An all -2**(WIDTH-1) input yields class 0, max -2**(WIDTH-1).
- rst mid-operation: abort immediately to IDLE, drop any pending result, clear the argmax unit. No spurious mem_ren or argmax_enable in the cycle after rst deasserts.

Test Plan:
- Basic: N=8, base=0, G=2; class 11 = 100, all others ≤ 50. Require result_class=11, result_max=100, result_valid rising exactly 6 cycles after start, mem_raddr 0 then 1.
- Single group, G=1: the max is at lane 5 = -3 and all others are -20. Require class 5, max -3, result_valid 5 cycles after start, exactly one argmax_enable pulse.
- Tie and minimum values:
  - Class 2 = class 9 = 77 → class 2.
  - All logits -128 → class 0, max -128.
- Backpressure and address wrap:
  - base=15, G=2 → addresses 15 then 0.
  - Hold result_ready=0 for 10 cycles: outputs stable, start pulses ignored, busy=1.
  - Then ready=1 → IDLE next cycle; a fresh start is accepted the cycle after.
- Reset mid-READ: assert rst during the second READ cycle of G=4. Then:
  - argmax_clear=1 while rst is high;
  - after rst deasserts: no enables, result_valid=0;
  - a new start yields the correct class from fresh data only.

Source files
------------

// File: rtl/argmax_readout_sequencer_if.sv
// SRAM read bus and result handshake shared by the readout sequencer and its neighbours.
// The master side belongs to the sequencer; the slave side belongs to the SRAM and the host.
interface argmax_readout_sequencer_if #(
    parameter int WIDTH               = 8,
    parameter int N                   = 8,
    parameter int SERIAL_ARGMAX_WIDTH = 4,
    parameter int ADDR_WIDTH          = 4
);
    logic                           mem_ren;
    logic [ADDR_WIDTH-1:0]          mem_raddr;
    logic [N*WIDTH-1:0]             mem_rdata;
    logic                           result_valid;
    logic                           result_ready;
    logic [SERIAL_ARGMAX_WIDTH-1:0] result_class;
    logic signed [WIDTH-1:0]        result_max;

    modport master (
        output mem_ren,
        output mem_raddr,
        input  mem_rdata,
        output result_valid,
        output result_class,
        output result_max,
        input  result_ready
    );

    modport slave (
        input  mem_ren,
        input  mem_raddr,
        output mem_rdata,
        input  result_valid,
        input  result_class,
        input  result_max,
        output result_ready
    );
endinterface

// File: rtl/argmax_readout_sequencer.sv
// Streams G groups of N logits from the output SRAM into the serial-parallel argmax unit,
// then holds the winning class and max logit on a valid/ready result port.
module argmax_readout_sequencer #(
    parameter int   WIDTH               = 8,
    parameter int   N                   = 8,
    parameter int   SERIAL_ARGMAX_WIDTH = 4,
    parameter int   ADDR_WIDTH          = 4,
    localparam int  GROUP_WIDTH         = SERIAL_ARGMAX_WIDTH - $clog2(N)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [GROUP_WIDTH-1:0]             num_groups_m1,
    output logic                               busy,
    argmax_readout_sequencer_if.master         bus,
    output logic                               argmax_clear,
    output logic                               argmax_enable,
    output logic [N*WIDTH-1:0]                 argmax_data,
    input  logic [SERIAL_ARGMAX_WIDTH-1:0]     argmax_in,
    input  logic signed [WIDTH-1:0]            max_in
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLEAR   = 3'd1;
    localparam logic [2:0] READ    = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;
    localparam logic [2:0] HOLD    = 3'd5;

    // Group address relative to base; the SRAM address space wraps.
    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(
        input logic [ADDR_WIDTH-1:0]  base,
        input logic [GROUP_WIDTH-1:0] k
    );
        return base + ADDR_WIDTH'(k);
    endfunction

    logic [2:0]                     state;
    logic [2:0]                     state_nxt;
    logic [ADDR_WIDTH-1:0]          base_q;
    logic [GROUP_WIDTH-1:0]         ngm1_q;
    logic [GROUP_WIDTH-1:0]         grp_cnt;
    logic                           vld_p0;
    logic                           vld_p1;
    logic                           result_valid_q;
    logic [SERIAL_ARGMAX_WIDTH-1:0] result_class_q;
    logic signed [WIDTH-1:0]        result_max_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = READ;
            READ:    if (grp_cnt == ngm1_q) state_nxt = DRAIN;
            DRAIN:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (result_valid_q && bus.result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grp_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == READ)
                grp_cnt <= grp_cnt + GROUP_WIDTH'(1);
            else
                grp_cnt <= '0;
        end
    end

    // Request parameters are latched once per readout and never need a reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            base_q <= base_addr;
            ngm1_q <= num_groups_m1;
        end
    end

    // Stage p0: read issue
    assign vld_p0        = (state == READ);
    assign bus.mem_ren   = vld_p0;
    assign bus.mem_raddr = wrap_addr(base_q, grp_cnt);

    // Stage p1: SRAM data returns, argmax unit consumes it
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    assign argmax_enable = vld_p1;
    assign argmax_data   = bus.mem_rdata;
    assign argmax_clear  = rst | (state == CLEAR);

    // Result register: filled in CAPTURE, held until the host takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_max_q   <= '0;
        end else if (state == CAPTURE) begin
            result_valid_q <= 1'b1;
            result_class_q <= argmax_in;
            result_max_q   <= max_in;
        end else if (state == HOLD && bus.result_ready) begin
            result_valid_q <= 1'b0;
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.result_class = result_class_q;
    assign bus.result_max   = result_max_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_argmax_readout_sequencer.sv
// Directed bench for argmax_readout_sequencer with a behavioural SRAM and argmax unit.
module tb_argmax_readout_sequencer;
    localparam int WIDTH = 8;
    localparam int N     = 8;
    localparam int SAW   = 5;
    localparam int AW    = 4;
    localparam int GW    = SAW - $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    start;
    logic [AW-1:0]           base_addr;
    logic [GW-1:0]           num_groups_m1;
    logic                    busy;
    logic                    argmax_clear;
    logic                    argmax_enable;
    logic [N*WIDTH-1:0]      argmax_data;
    logic [SAW-1:0]          argmax_in;
    logic signed [WIDTH-1:0] max_in;

    int checks = 0;
    int errors = 0;

    argmax_readout_sequencer_if #(
        .WIDTH(WIDTH), .N(N), .SERIAL_ARGMAX_WIDTH(SAW), .ADDR_WIDTH(AW)
    ) bus ();

    argmax_readout_sequencer #(
        .WIDTH(WIDTH), .N(N), .SERIAL_ARGMAX_WIDTH(SAW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_groups_m1(num_groups_m1), .busy(busy), .bus(bus),
        .argmax_clear(argmax_clear), .argmax_enable(argmax_enable),
        .argmax_data(argmax_data), .argmax_in(argmax_in), .max_in(max_in)
    );

    // SRAM with one-cycle read latency
    logic [N*WIDTH-1:0] mem [16];
    always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr];

    // Serial-parallel argmax unit: strict >, earliest class wins
    logic signed [WIDTH-1:0] am_max;
    logic [SAW-1:0]          am_idx;
    logic [GW-1:0]           am_grp;
    always @(posedge clk) begin : argmax_model
        logic signed [WIDTH-1:0] m;
        logic signed [WIDTH-1:0] lane;
        logic [SAW-1:0]          ix;
        if (argmax_clear) begin
            am_max <= -8'sd128;
            am_idx <= '0;
            am_grp <= '0;
        end else if (argmax_enable) begin
            m  = am_max;
            ix = am_idx;
            for (int i = 0; i < N; i++) begin
                lane = $signed(argmax_data[i*WIDTH +: WIDTH]);
                if (lane > m) begin
                    m  = lane;
                    ix = {am_grp, 3'(i)};
                end
            end
            am_max <= m;
            am_idx <= ix;
            am_grp <= am_grp + GW'(1);
        end
    end
    assign argmax_in = am_idx;
    assign max_in    = am_max;

    task automatic fill_word(input int a, input logic signed [WIDTH-1:0] v);
        for (int i = 0; i < N; i++) mem[a][i*WIDTH +: WIDTH] = v;
    endtask

    task automatic set_lane(input int a, input int lane, input logic signed [WIDTH-1:0] v);
        mem[a][lane*WIDTH +: WIDTH] = v;
    endtask

    // Leaves the bench at the falling edge inside cycle 1 (cycle 0 = start sampled).
    task automatic launch(input logic [AW-1:0] b, input logic [GW-1:0] g);
        @(negedge clk);
        start = 1'b1; base_addr = b; num_groups_m1 = g;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records activity from cycle 1 until result_valid rises (or a cycle budget expires).
    task automatic observe(output int vcyc, output int nen, output int nren,
                           output logic [AW-1:0] a0, output logic [AW-1:0] a1);
        vcyc = -1; nen = 0; nren = 0; a0 = '0; a1 = '0;
        for (int c = 1; c <= 30 && vcyc < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (argmax_enable) nen++;
            if (bus.mem_ren) begin
                if (nren == 0) a0 = bus.mem_raddr;
                if (nren == 1) a1 = bus.mem_raddr;
                nren++;
            end
            if (bus.result_valid) vcyc = c;
        end
    endtask

    task automatic accept();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (argmax_clear !== 1'b1) begin errors++; $display("FAIL reset_clear got %0b want 1", argmax_clear); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %0b want 0", bus.mem_ren); end
        checks++; if (argmax_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", argmax_enable); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.result_valid); end
        checks++; if (bus.result_class !== 5'd0) begin errors++; $display("FAIL reset_class got %0d want 0", bus.result_class); end
        checks++; if (bus.result_max !== 8'sd0) begin errors++; $display("FAIL reset_max got %0d want 0", bus.result_max); end
        checks++; if (argmax_clear !== 1'b0) begin errors++; $display("FAIL idle_clear got %0b want 0", argmax_clear); end
    endtask

    task automatic test_basic();
        int vc, ne, nr; logic [AW-1:0] a0, a1;
        fill_word(0, 8'sd10); set_lane(0, 6, 8'sd50);
        fill_word(1, 8'sd20); set_lane(1, 0, 8'sd50); set_lane(1, 3, 8'sd100);
        launch(4'd0, 2'd1);
        observe(vc, ne, nr, a0, a1);
        checks++; if (vc !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", vc); end
        checks++; if (nr !== 2) begin errors++; $display("FAIL basic_reads got %0d want 2", nr); end
        checks++; if (a0 !== 4'd0 || a1 !== 4'd1) begin errors++; $display("FAIL basic_addr got %0d,%0d want 0,1", a0, a1); end
        checks++; if (ne !== 2) begin errors++; $display("FAIL basic_enables got %0d want 2", ne); end
        checks++; if (bus.result_class !== 5'd11) begin errors++; $display("FAIL basic_class got %0d want 11", bus.result_class); end
        checks++; if (bus.result_max !== 8'sd100) begin errors++; $display("FAIL basic_max got %0d want 100", bus.result_max); end
        accept();
        checks++; if (busy !== 1'b0 || bus.result_valid !== 1'b0) begin errors++; $display("FAIL basic_release got busy=%0b valid=%0b want 0,0", busy, bus.result_valid); end
    endtask

    task automatic test_single_group();
        int vc, ne, nr; logic [AW-1:0] a0, a1;
        fill_word(4, -8'sd20); set_lane(4, 5, -8'sd3);
        launch(4'd4, 2'd0);
        observe(vc, ne, nr, a0, a1);
        checks++; if (vc !== 5) begin errors++; $display("FAIL single_latency got %0d want 5", vc); end
        checks++; if (ne !== 1) begin errors++; $display("FAIL single_enables got %0d want 1", ne); end
        checks++; if (nr !== 1 || a0 !== 4'd4) begin errors++; $display("FAIL single_read got n=%0d a=%0d want 1,4", nr, a0); end
        checks++; if (bus.result_class !== 5'd5) begin errors++; $display("FAIL single_class got %0d want 5", bus.result_class); end
        checks++; if (bus.result_max !== -8'sd3) begin errors++; $display("FAIL single_max got %0d want -3", bus.result_max); end
        accept();
    endtask

    task automatic test_tie_and_min();
        int vc, ne, nr; logic [AW-1:0] a0, a1;
        fill_word(6, 8'sd0); set_lane(6, 2, 8'sd77);
        fill_word(7, 8'sd0); set_lane(7, 1, 8'sd77);
        launch(4'd6, 2'd1);
        observe(vc, ne, nr, a0, a1);
        checks++; if (bus.result_class !== 5'd2) begin errors++; $display("FAIL tie_class got %0d want 2", bus.result_class); end
        checks++; if (bus.result_max !== 8'sd77) begin errors++; $display("FAIL tie_max got %0d want 77", bus.result_max); end
        accept();
        fill_word(8, -8'sd128); fill_word(9, -8'sd128);
        launch(4'd8, 2'd1);
        observe(vc, ne, nr, a0, a1);
        checks++; if (vc !== 6) begin errors++; $display("FAIL min_latency got %0d want 6", vc); end
        checks++; if (bus.result_class !== 5'd0) begin errors++; $display("FAIL min_class got %0d want 0", bus.result_class); end
        checks++; if (bus.result_max !== -8'sd128) begin errors++; $display("FAIL min_max got %0d want -128", bus.result_max); end
        accept();
    endtask

    task automatic test_backpressure_wrap();
        int vc, ne, nr; logic [AW-1:0] a0, a1;
        fill_word(15, 8'sd1); set_lane(15, 7, 8'sd60);
        fill_word(0, 8'sd1);  set_lane(0, 0, 8'sd90);
        launch(4'd15, 2'd1);
        observe(vc, ne, nr, a0, a1);
        checks++; if (a0 !== 4'd15 || a1 !== 4'd0) begin errors++; $display("FAIL wrap_addr got %0d,%0d want 15,0", a0, a1); end
        checks++; if (vc !== 6) begin errors++; $display("FAIL wrap_latency got %0d want 6", vc); end
        for (int i = 0; i < 10; i++) begin
            start = (i == 2 || i == 6);
            base_addr = 4'd3;
            @(negedge clk);
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result_class !== 5'd8 || bus.result_max !== 8'sd90
                || busy !== 1'b1 || bus.mem_ren !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got v=%0b c=%0d m=%0d busy=%0b ren=%0b want 1,8,90,1,0",
                         i, bus.result_valid, bus.result_class, bus.result_max, busy, bus.mem_ren);
            end
        end
        start = 1'b1; base_addr = 4'd15; num_groups_m1 = 2'd1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        checks++; if (busy !== 1'b0 || bus.result_valid !== 1'b0) begin errors++; $display("FAIL handshake_idle got busy=%0b valid=%0b want 0,0", busy, bus.result_valid); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %0b want 1", busy); end
        observe(vc, ne, nr, a0, a1);
        checks++; if (vc !== 6 || bus.result_class !== 5'd8) begin errors++; $display("FAIL restart_result got cyc=%0d class=%0d want 6,8", vc, bus.result_class); end
        accept();
    endtask

    task automatic test_reset_mid_read();
        int vc, ne, nr; logic [AW-1:0] a0, a1;
        for (int a = 10; a < 14; a++) fill_word(a, 8'sd0);
        set_lane(10, 0, 8'sd127);
        launch(4'd10, 2'd3);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 4'd11) begin errors++; $display("FAIL mid_read got ren=%0b a=%0d want 1,11", bus.mem_ren, bus.mem_raddr); end
        rst = 1'b1;
        #1;
        checks++; if (argmax_clear !== 1'b1) begin errors++; $display("FAIL rst_clear_comb got %0b want 1", argmax_clear); end
        @(negedge clk);
        checks++; if (argmax_clear !== 1'b1 || busy !== 1'b0 || argmax_enable !== 1'b0) begin errors++; $display("FAIL rst_abort got clr=%0b busy=%0b en=%0b want 1,0,0", argmax_clear, busy, argmax_enable); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (argmax_enable !== 1'b0 || bus.mem_ren !== 1'b0 || bus.result_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_rst_quiet cycle %0d got en=%0b ren=%0b v=%0b busy=%0b want 0,0,0,0",
                         i, argmax_enable, bus.mem_ren, bus.result_valid, busy);
            end
        end
        set_lane(10, 0, 8'sd0);
        set_lane(11, 2, -8'sd5);
        set_lane(13, 7, 8'sd120);
        launch(4'd10, 2'd3);
        observe(vc, ne, nr, a0, a1);
        checks++; if (vc !== 8) begin errors++; $display("FAIL full_latency got %0d want 8", vc); end
        checks++; if (ne !== 4 || nr !== 4) begin errors++; $display("FAIL full_counts got en=%0d rd=%0d want 4,4", ne, nr); end
        checks++; if (bus.result_class !== 5'd31) begin errors++; $display("FAIL full_class got %0d want 31", bus.result_class); end
        checks++; if (bus.result_max !== 8'sd120) begin errors++; $display("FAIL full_max got %0d want 120", bus.result_max); end
        accept();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_groups_m1 = '0;
        bus.result_ready = 1'b0;
        for (int a = 0; a < 16; a++) mem[a] = '0;
        test_reset();
        test_basic();
        test_single_group();
        test_tie_and_min();
        test_backpressure_wrap();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
